channel_decoder_coef_port: RTL

//  Master-side controller for the channel_decoder coefficient RAM (1-cycle read latency, single port).

---
 rtl/channel_decoder_coef_port.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/channel_decoder_coef_port.sv
// Master-side controller for the channel_decoder coefficient RAM: streams a LOAD into the RAM
// or streams a READ out through a 2-entry skid FIFO that absorbs the 1-cycle RAM latency.
module channel_decoder_coef_port #(
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned AWIDTH   = 7,
  parameter int unsigned MEM_SIZE = 72
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              load_err,
  input  logic [DWIDTH-1:0] in_tdata,
  input  logic              in_tvalid,
  input  logic              in_tlast,
  output logic              in_tready,
  output logic [DWIDTH-1:0] coef_tdata,
  output logic              coef_tvalid,
  output logic              coef_tlast,
  input  logic              coef_tready,
  output logic [AWIDTH-1:0] address0,
  output logic              ce0,
  output logic              we0,
  output logic [DWIDTH-1:0] d0,
  input  logic [DWIDTH-1:0] q0
);

  localparam int unsigned OCC_W = 3;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;

  state_t                   state;
  logic [AWIDTH-1:0]        addr;
  logic                     inflight;
  logic                     inflight_last;
  logic [1:0][DWIDTH-1:0]   fifo_data;
  logic [1:0]               fifo_last;
  logic                     rd_ptr;
  logic                     wr_ptr;
  logic [1:0]               count;

  logic addr_last;
  logic load_beat;
  logic pop;
  logic push;
  logic issue;

  assign addr_last = (addr == LAST_ADDR);
  assign load_beat = (state == LOAD) && in_tvalid;
  assign pop       = coef_tvalid && coef_tready;
  assign push      = inflight;
  // Issue only if the read can still land in the FIFO, counting this cycle's pop.
  assign issue     = (state == READ) &&
                     ((OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop)) < OCC_W'(2));

  assign in_tready = (state == LOAD);
  assign ce0       = load_beat || issue;
  assign we0       = load_beat;
  assign d0        = load_beat ? in_tdata : '0;
  assign address0  = ce0 ? addr : '0;

  assign coef_tvalid = (count != 2'd0);
  assign coef_tdata  = fifo_data[rd_ptr];
  assign coef_tlast  = fifo_last[rd_ptr] && coef_tvalid;

  // Control FSM with registered busy/done/load_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            load_err <= 1'b0;
            addr     <= '0;
            busy     <= 1'b1;
            state    <= mode ? LOAD : READ;
          end
        end
        LOAD: begin
          if (in_tvalid) begin
            if (in_tlast != addr_last) load_err <= 1'b1;
            if (addr_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              addr <= addr + AWIDTH'(1);
            end
          end
        end
        READ: begin
          if (issue) begin
            inflight_last <= addr_last;
            if (addr_last) state <= DRAIN;
            else           addr  <= addr + AWIDTH'(1);
          end
        end
        DRAIN: begin
          if ((count == 2'd0) && !inflight) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Skid FIFO: first-word fall-through, never pushed while full.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_data <= '0;
      fifo_last <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= q0;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule
